fft_pingpong_buf: RTL and testbench
===================================

Name: fft_pingpong_buf

Overview:
- Parametrised double-buffered (ping-pong) frame store between FFT butterfly stages.
- Writer fills one bank while reader drains the other.
- Each beat carries LANES samples of DATA_W bits; a frame is DEPTH beats.
- Adds valid/ready handshakes, per-bank full tracking and selectable natural or bit-reversed read order. Generalises the fixed 2-bank, 2x2-sample memory.

Parameters:
- DATA_W, 8, bits per sample.
- LANES, 4, samples per beat.
- DEPTH, 4, beats per frame; power of two, >= 2.
- AW, $clog2(DEPTH), beat-pointer width (derived, not overridden).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-high reset (name kept for codebase consistency; asserted = 1).
- wr_valid  in  1  write beat offered.
- wr_ready  out  1  write beat accepted when wr_valid && wr_ready.
- wr_data  in  LANES*DATA_W  write beat; lane 0 in LSBs.
- rd_mode  in  1  0 = natural order, 1 = bit-reversed beat order; sampled on first beat of each read frame.
- rd_valid  out  1  read beat available.
- rd_ready  in  1  read beat consumed when rd_valid && rd_ready.
- rd_data  out  LANES*DATA_W  read beat; combinational from storage.
- rd_last  out  1  high with final beat of a read frame.

Behaviour:
- Storage: 2 banks x DEPTH beats x LANES*DATA_W. Not cleared by reset.
- State registers:
  - wr_bank, rd_bank (1 bit each)
  - wr_ptr, rd_ptr (AW bits each)
  - full[1:0]
  - mode_q (latched read mode)
- Reset (rst_n = 1 at clk edge), all values after reset:
  - wr_bank = rd_bank = 0; wr_ptr = rd_ptr = 0; full = 2'b00; mode_q = 0.
  - Outputs: wr_ready = 1, rd_valid = 0, rd_last = 0.
  - Reset mid-frame discards partial write and read frames.
- Write side:
  - wr_ready = !full[wr_bank].
  - On each write transfer: storage[wr_bank][wr_ptr] <= wr_data; wr_ptr increments.
  - When wr_ptr == DEPTH-1: wr_ptr wraps to 0, full[wr_bank] <= 1, wr_bank toggles.
- Read side:
  - rd_valid = full[rd_bank].
  - Effective address: rd_ptr if the mode in use is 0, else bitrev(rd_ptr) over AW bits.
  - Mode in use: rd_mode when rd_ptr == 0, else mode_q. Beat 0 maps to address 0 in either mode.
  - rd_data = storage[rd_bank][effective address].
  - rd_last = rd_valid && rd_ptr == DEPTH-1.
  - On each read transfer: rd_ptr increments. If rd_ptr == 0, mode_q <= rd_mode.
  - When rd_ptr == DEPTH-1: rd_ptr wraps to 0, full[rd_bank] <= 0, rd_bank toggles.
- Latency:
  - Written frame becomes readable the cycle after its last write transfer.
  - Freed bank becomes writable the cycle after its last read transfer.
  - Read data has zero-cycle latency from pointer.
- Simultaneous events:
  - Write completing bank A and read completing bank B in the same cycle both take effect.
  - A == B cannot occur: a bank is never written while full.
  - Both banks full: wr_ready = 0; writer stalls.
  - Both banks empty: rd_valid = 0.
- Stalls: rd_data and rd_last are held stable while rd_valid && !rd_ready.
- rd_mode changes mid-frame have no effect until the next frame's first beat.

Optional Feature:
- Macro: FFT_PINGPONG_STATUS_EN.
- Defined: adds two outputs.
  - frames_done [15:0]: increments on each completed read frame, wraps at 0xFFFF -> 0, reset 0.
  - wr_stall_seen [0:0]: sticky, set in any cycle with wr_valid && !wr_ready, cleared only by reset, reset 0.
- Undefined: ports and logic absent; core behaviour identical.

Test Plan (DATA_W = 8, LANES = 4, DEPTH = 4):
- Reset, then idle -> wr_ready = 1, rd_valid = 0, rd_last = 0.
- Write beats 0x03020100, 0x13121110, 0x23222120, 0x33323130 with rd_mode = 0 and rd_ready = 1.
  - rd_valid rises the cycle after the 4th write.
  - Reads return the same order; rd_last on the 4th beat.
- Same frame with rd_mode = 1 -> read order beats 0, 2, 1, 3 (0x03020100, 0x23222120, 0x13121110, 0x33323130).
  - Toggling rd_mode after beat 0 does not change this order.
- Hold rd_ready = 0 and write 2 frames -> wr_ready = 0 after the 8th write.
  - The 9th beat is not accepted.
  - Release rd_ready: after the 4th read, wr_ready = 1 next cycle; frames read out in write order.
- Continuous streaming, wr_valid = rd_valid-driven = 1 for 10 frames -> no lost or duplicated beats.
  - Completion events on opposite banks in the same cycle both take effect.
- Assert rst_n after 2 writes and 1 read -> next cycle wr_ready = 1, rd_valid = 0.
  - A new full frame then reads back correctly.
  - With FFT_PINGPONG_STATUS_EN: frames_done = 0, wr_stall_seen = 0 after reset.

Source files
------------

// File: rtl/fft_pingpong_buf.sv
// ---------------------------------------------------------------------------
// fft_pingpong_buf
//
// Double-buffered (ping-pong) frame store that sits between two FFT butterfly
// stages. The writer fills one bank while the reader drains the other. Each
// beat carries LANES samples of DATA_W bits, and a frame is DEPTH beats. The
// reader can take a frame in natural beat order or in bit-reversed beat order.
//
// Ports:
//   i_clk           single clock, rising edge
//   i_rst_n         synchronous reset, ACTIVE HIGH despite the name
//   i_wr_valid      write beat offered
//   o_wr_ready      write beat accepted when i_wr_valid && o_wr_ready
//   i_wr_data       write beat, lane 0 in the LSBs
//   i_rd_mode       0 = natural order, 1 = bit-reversed beat order;
//                   sampled on the first beat of each read frame
//   o_rd_valid      read beat available
//   i_rd_ready      read beat consumed when o_rd_valid && i_rd_ready
//   o_rd_data       read beat, combinational from storage
//   o_rd_last       high with the final beat of a read frame
//
// Optional status outputs, present only when FFT_PINGPONG_STATUS_EN is
// defined:
//   o_frames_done   count of completed read frames, wraps at 16 bits
//   o_wr_stall_seen sticky flag, set whenever the writer was refused
// ---------------------------------------------------------------------------
module fft_pingpong_buf #(
    parameter int DATA_W = 8,
    parameter int LANES  = 4,
    parameter int DEPTH  = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_wr_valid,
    output logic                    o_wr_ready,
    input  logic [LANES*DATA_W-1:0] i_wr_data,
    input  logic                    i_rd_mode,
    output logic                    o_rd_valid,
    input  logic                    i_rd_ready,
    output logic [LANES*DATA_W-1:0] o_rd_data,
    output logic                    o_rd_last
`ifdef FFT_PINGPONG_STATUS_EN
    ,
    output logic [15:0]             o_frames_done,
    output logic [0:0]              o_wr_stall_seen
`endif
);

    localparam int W = LANES * DATA_W;
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    // Reverses the bit order of a beat index; used to fetch beats in the
    // bit-reversed order an in-place FFT stage expects.
    function automatic logic [AW-1:0] bitRev(input logic [AW-1:0] ptr);
        logic [AW-1:0] result;
        result = '0;
        for (int i = 0; i < AW; i++) begin
            result[i] = ptr[AW-1-i];
        end
        return result;
    endfunction

    logic [W-1:0]  r_mem [2][DEPTH];
    logic          r_wrBank;
    logic          r_rdBank;
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [1:0]    r_full;
    logic          r_modeQ;

    logic          w_wrReady;
    logic          w_rdValid;
    logic          w_wrFire;
    logic          w_rdFire;
    logic          w_wrDone;
    logic          w_rdDone;
    logic          w_modeUse;
    logic [AW-1:0] w_rdAddr;
    logic [1:0]    w_setMask;
    logic [1:0]    w_clrMask;

    // Handshake and frame-completion decode. A bank is never written while it
    // is full, so a write completion and a read completion in the same cycle
    // always land on opposite banks and can be applied independently.
    // On the first beat the live i_rd_mode selects the order; bit-reversal of
    // index 0 is 0, so a stall on beat 0 keeps the data stable even if the
    // mode input wiggles.
    always_comb begin
        w_wrReady = ~r_full[r_wrBank];
        w_rdValid = r_full[r_rdBank];
        w_wrFire  = i_wr_valid & w_wrReady;
        w_rdFire  = i_rd_ready & w_rdValid;
        w_wrDone  = w_wrFire & (r_wrPtr == LAST_PTR);
        w_rdDone  = w_rdFire & (r_rdPtr == LAST_PTR);
        w_modeUse = (r_rdPtr == '0) ? i_rd_mode : r_modeQ;
        w_rdAddr  = w_modeUse ? bitRev(r_rdPtr) : r_rdPtr;
        w_setMask = 2'b00;
        w_clrMask = 2'b00;
        if (w_wrDone) begin
            w_setMask[r_wrBank] = 1'b1;
        end
        if (w_rdDone) begin
            w_clrMask[r_rdBank] = 1'b1;
        end
    end

    // Bank/pointer bookkeeping. Reset throws away any partially written or
    // partially read frame by clearing both full flags and both pointers.
    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            r_wrBank <= 1'b0;
            r_rdBank <= 1'b0;
            r_wrPtr  <= '0;
            r_rdPtr  <= '0;
            r_full   <= 2'b00;
            r_modeQ  <= 1'b0;
        end else begin
            r_full <= (r_full | w_setMask) & ~w_clrMask;
            if (w_wrFire) begin
                r_wrPtr <= r_wrPtr + 1'b1;
                if (w_wrDone) begin
                    r_wrBank <= ~r_wrBank;
                end
            end
            if (w_rdFire) begin
                r_rdPtr <= r_rdPtr + 1'b1;
                if (r_rdPtr == '0) begin
                    r_modeQ <= i_rd_mode;
                end
                if (w_rdDone) begin
                    r_rdBank <= ~r_rdBank;
                end
            end
        end
    end

    // Frame storage has no reset so it can map onto plain RAM; the full flags
    // alone decide whether its contents are meaningful.
    always_ff @(posedge i_clk) begin
        if (w_wrFire && !i_rst_n) begin
            r_mem[r_wrBank][r_wrPtr] <= i_wr_data;
        end
    end

    assign o_wr_ready = w_wrReady;
    assign o_rd_valid = w_rdValid;
    assign o_rd_data  = r_mem[r_rdBank][w_rdAddr];
    assign o_rd_last  = w_rdValid & (r_rdPtr == LAST_PTR);

`ifdef FFT_PINGPONG_STATUS_EN
    logic [15:0] r_framesDone;
    logic        r_wrStallSeen;

    // Status counters: completed read frames (free-running, wraps) and a
    // sticky record of any cycle where the writer was held off.
    always_ff @(posedge i_clk) begin
        if (i_rst_n) begin
            r_framesDone  <= '0;
            r_wrStallSeen <= 1'b0;
        end else begin
            if (w_rdDone) begin
                r_framesDone <= r_framesDone + 16'd1;
            end
            if (i_wr_valid && !w_wrReady) begin
                r_wrStallSeen <= 1'b1;
            end
        end
    end

    assign o_frames_done   = r_framesDone;
    assign o_wr_stall_seen = r_wrStallSeen;
`endif

endmodule

// File: tb/tb_fft_pingpong_buf.sv
// ---------------------------------------------------------------------------
// tb_fft_pingpong_buf
//
// Self-checking bench for fft_pingpong_buf with DATA_W=8, LANES=4, DEPTH=4.
// A table of directed cycles covers natural and bit-reversed readout; then
// hand-written sequences cover backpressure and mid-frame reset, followed by
// continuous streaming and random traffic. A frame-level reference model
// (queue of complete frames plus a partial frame being filled) supplies the
// expected outputs every cycle.
// ---------------------------------------------------------------------------
module tb_fft_pingpong_buf;

    localparam int DATA_W = 8;
    localparam int LANES  = 4;
    localparam int DEPTH  = 4;
    localparam int W      = LANES * DATA_W;

    logic         clk;
    logic         rst;
    logic         wrValid;
    logic         wrReady;
    logic [W-1:0] wrData;
    logic         rdMode;
    logic         rdValid;
    logic         rdReady;
    logic [W-1:0] rdData;
    logic         rdLast;
`ifdef FFT_PINGPONG_STATUS_EN
    logic [15:0]  framesDone;
    logic [0:0]   wrStallSeen;
`endif

    fft_pingpong_buf #(
        .DATA_W(DATA_W),
        .LANES (LANES),
        .DEPTH (DEPTH)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst),
        .i_wr_valid(wrValid),
        .o_wr_ready(wrReady),
        .i_wr_data (wrData),
        .i_rd_mode (rdMode),
        .o_rd_valid(rdValid),
        .i_rd_ready(rdReady),
        .o_rd_data (rdData),
        .o_rd_last (rdLast)
`ifdef FFT_PINGPONG_STATUS_EN
        ,
        .o_frames_done  (framesDone),
        .o_wr_stall_seen(wrStallSeen)
`endif
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef logic [W-1:0] frame_t [DEPTH];

    typedef struct {
        logic         wv;
        logic [W-1:0] wd;
        logic         rm;
        logic         rr;
        logic         eWrReady;
        logic         eRdValid;
        logic [W-1:0] eData;
        logic         eLast;
    } vec_t;

    int     cmpCount;
    int     failCount;
    int     lastSeen;

    frame_t mFrames[$];
    frame_t mPartial;
    int     mWrIdx;
    int     mRdIdx;
    bit     mModeQ;
    bit     mWrFire;
    bit     mRdFire;

    // Bit-reversed beat index computed arithmetically from the index value.
    function automatic int revIndex(input int idx);
        int bits;
        int rev;
        bits = $clog2(DEPTH);
        rev  = 0;
        for (int b = 0; b < bits; b++) begin
            if (((idx >> b) & 1) == 1) begin
                rev = rev | (1 << (bits - 1 - b));
            end
        end
        return rev;
    endfunction

    // Records one comparison and reports it if it does not hold.
    task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        cmpCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one cycle's inputs at the falling edge and lets them settle.
    task automatic applyStimulus(input logic wv, input logic [W-1:0] wd, input logic rm, input logic rr);
        @(negedge clk);
        wrValid = wv;
        wrData  = wd;
        rdMode  = rm;
        rdReady = rr;
        #1;
    endtask

    // Compares all DUT outputs against the frame-queue model.
    task automatic modelCheck();
        bit           expWr;
        bit           expRv;
        bit           expLast;
        bit           modeUse;
        int           beat;
        logic [W-1:0] expData;
        expWr   = (mFrames.size() < 2);
        expRv   = (mFrames.size() > 0);
        expLast = expRv && (mRdIdx == DEPTH - 1);
        checkOutput("modelWrReady", W'(wrReady), W'(expWr));
        checkOutput("modelRdValid", W'(rdValid), W'(expRv));
        checkOutput("modelRdLast", W'(rdLast), W'(expLast));
        if (expRv) begin
            modeUse = (mRdIdx == 0) ? rdMode : mModeQ;
            beat    = modeUse ? revIndex(mRdIdx) : mRdIdx;
            expData = mFrames[0][beat];
            checkOutput("modelRdData", rdData, expData);
        end
        if (rdValid && rdReady && rdLast) begin
            lastSeen++;
        end
        mWrFire = wrValid && expWr;
        mRdFire = rdReady && expRv;
    endtask

    // Advances through the rising edge and applies the transfers to the model.
    task automatic clockAndUpdate();
        @(posedge clk);
        if (mRdFire) begin
            if (mRdIdx == 0) begin
                mModeQ = rdMode;
            end
            if (mRdIdx == DEPTH - 1) begin
                void'(mFrames.pop_front());
                mRdIdx = 0;
            end else begin
                mRdIdx++;
            end
        end
        if (mWrFire) begin
            mPartial[mWrIdx] = wrData;
            if (mWrIdx == DEPTH - 1) begin
                mFrames.push_back(mPartial);
                mWrIdx = 0;
            end else begin
                mWrIdx++;
            end
        end
    endtask

    // One fully model-checked cycle; reports whether the write was taken.
    task automatic cycle(input logic wv, input logic [W-1:0] wd, input logic rm, input logic rr,
                         output bit accepted);
        applyStimulus(wv, wd, rm, rr);
        modelCheck();
        accepted = mWrFire;
        clockAndUpdate();
    endtask

    // Synchronous reset pulse; the model forgets every stored frame.
    task automatic doReset();
        @(negedge clk);
        rst     = 1'b1;
        wrValid = 1'b0;
        rdReady = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mFrames.delete();
        mWrIdx = 0;
        mRdIdx = 0;
        mModeQ = 1'b0;
    endtask

    vec_t vecs[18];

    initial begin
        bit           acc;
        logic [W-1:0] pend;
        int           written;
        logic [W-1:0] b0, b1, b2, b3;

        b0 = 32'h03020100;
        b1 = 32'h13121110;
        b2 = 32'h23222120;
        b3 = 32'h33323130;
        vecs[0]  = '{1'b1, b0, 1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0};
        vecs[1]  = '{1'b1, b1, 1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0};
        vecs[2]  = '{1'b1, b2, 1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0};
        vecs[3]  = '{1'b1, b3, 1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0};
        vecs[4]  = '{1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b1, b0, 1'b0};
        vecs[5]  = '{1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b1, b1, 1'b0};
        vecs[6]  = '{1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b1, b2, 1'b0};
        vecs[7]  = '{1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b1, b3, 1'b1};
        vecs[8]  = '{1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0};
        vecs[9]  = '{1'b1, b0, 1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0};
        vecs[10] = '{1'b1, b1, 1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0};
        vecs[11] = '{1'b1, b2, 1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0};
        vecs[12] = '{1'b1, b3, 1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0};
        vecs[13] = '{1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b1, b0, 1'b0};
        vecs[14] = '{1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b1, b2, 1'b0};
        vecs[15] = '{1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b1, b1, 1'b0};
        vecs[16] = '{1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b1, b3, 1'b1};
        vecs[17] = '{1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0};

        cmpCount  = 0;
        failCount = 0;
        lastSeen  = 0;
        mWrIdx    = 0;
        mRdIdx    = 0;
        mModeQ    = 1'b0;
        rst       = 1'b0;
        wrValid   = 1'b0;
        wrData    = '0;
        rdMode    = 1'b0;
        rdReady   = 1'b0;

        doReset();

        // Idle after reset.
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("resetWrReady", W'(wrReady), W'(1'b1));
        checkOutput("resetRdValid", W'(rdValid), W'(1'b0));
        checkOutput("resetRdLast", W'(rdLast), W'(1'b0));
`ifdef FFT_PINGPONG_STATUS_EN
        checkOutput("resetFramesDone", W'(framesDone), W'(16'd0));
        checkOutput("resetStallSeen", W'(wrStallSeen), W'(1'b0));
`endif
        modelCheck();
        clockAndUpdate();

        // Directed natural and bit-reversed frames from the table.
        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i].wv, vecs[i].wd, vecs[i].rm, vecs[i].rr);
            checkOutput($sformatf("vecWrReady%0d", i), W'(wrReady), W'(vecs[i].eWrReady));
            checkOutput($sformatf("vecRdValid%0d", i), W'(rdValid), W'(vecs[i].eRdValid));
            checkOutput($sformatf("vecRdLast%0d", i), W'(rdLast), W'(vecs[i].eLast));
            if (vecs[i].eRdValid) begin
                checkOutput($sformatf("vecRdData%0d", i), rdData, vecs[i].eData);
            end
            modelCheck();
            clockAndUpdate();
        end

        // Backpressure: fill both banks with the reader stalled.
        for (int i = 0; i < 2 * DEPTH; i++) begin
            cycle(1'b1, W'($urandom), 1'b0, 1'b0, acc);
        end
        pend = W'($urandom);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, pend, 1'b0, 1'b0);
            checkOutput("bothFullWrReady", W'(wrReady), W'(1'b0));
            checkOutput("bothFullRdValid", W'(rdValid), W'(1'b1));
            modelCheck();
            clockAndUpdate();
        end
`ifdef FFT_PINGPONG_STATUS_EN
        @(negedge clk);
        checkOutput("stallSeenSticky", W'(wrStallSeen), W'(1'b1));
`endif
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, pend, 1'b0, 1'b1, acc);
        end
        applyStimulus(1'b1, pend, 1'b0, 1'b1);
        checkOutput("wrReadyAfterFree", W'(wrReady), W'(1'b1));
        modelCheck();
        clockAndUpdate();
        written = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(written < DEPTH - 1, W'($urandom), 1'(i % 2), 1'b1, acc);
            if (acc) begin
                written++;
            end
        end

        // Mid-frame reset after a full frame, then two writes and one read.
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, W'($urandom), 1'b0, 1'b0, acc);
        end
        cycle(1'b1, W'($urandom), 1'b0, 1'b1, acc);
        cycle(1'b1, W'($urandom), 1'b0, 1'b0, acc);
        doReset();
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("midResetWrReady", W'(wrReady), W'(1'b1));
        checkOutput("midResetRdValid", W'(rdValid), W'(1'b0));
`ifdef FFT_PINGPONG_STATUS_EN
        checkOutput("midResetFramesDone", W'(framesDone), W'(16'd0));
        checkOutput("midResetStallSeen", W'(wrStallSeen), W'(1'b0));
`endif
        modelCheck();
        clockAndUpdate();
        for (int i = 0; i < 2 * DEPTH + 2; i++) begin
            cycle(i < DEPTH, W'($urandom), 1'b1, i >= DEPTH, acc);
        end

        // Continuous streaming of 10 frames with both sides always willing.
        lastSeen = 0;
        written  = 0;
        for (int i = 0; i < 10 * DEPTH + 8; i++) begin
            cycle(written < 10 * DEPTH, W'($urandom), 1'($urandom), 1'b1, acc);
            if (acc) begin
                written++;
            end
        end
        checkOutput("streamFrames", W'(lastSeen), W'(10));

        // Random traffic on both sides.
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom), W'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0), acc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, failCount);
        $finish;
    end

endmodule
